keypoint_collector: RTL and testbench

KEYPOINT_COLLECTOR -- requirements
Module: keypoint_collector

---
 rtl/keypoint_collector.sv | 170 +++++++++++++++++
 tb/tb_keypoint_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_collector.sv
// Keypoint collector: serialises per-scale local-max flags of a pixel into a record FIFO.
// Optional macro KPC_RESPONSE_STORE_EN keeps responses in the FIFO; otherwise kp_response is 0.
//   state | meaning
//   IDLE  | pending mask empty, next flagged pixel is accepted
//   SCAN  | pending mask non-zero, one flag emitted per free push slot
module keypoint_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_KP     = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    din_valid,
    input  logic [5:0]              max_flag,
    input  logic [6*DATA_WIDTH-1:0] response,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    kp_ready,
    output logic                    kp_valid,
    output logic [2:0]              kp_scale,
    output logic [9:0]              kp_x,
    output logic [9:0]              kp_y,
    output logic [DATA_WIDTH-1:0]   kp_response,
    output logic [10:0]             kp_count,
    output logic [15:0]             drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [10:0] MAX_KP_C = 11'(MAX_KP);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [5:0]    mask_q, mask_d, low_bit;
    logic [9:0]    px_q, py_q;
    logic [2:0]    idx;
    logic          cap, slot_free, last, emit, load, drop, push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill;
    logic [2:0]    mem_scale [FIFO_DEPTH];
    logic [9:0]    mem_x     [FIFO_DEPTH];
    logic [9:0]    mem_y     [FIFO_DEPTH];

    assign cap       = din_valid && (max_flag != 6'd0);
    assign slot_free = (fill != FULL_LVL);
    assign low_bit   = mask_q & (~mask_q + 6'd1);
    assign last      = ((mask_q & (mask_q - 6'd1)) == 6'd0);
    // Past MAX_KP the scan still consumes flags, it just stops pushing them.
    assign push      = emit && (kp_count < MAX_KP_C);
    assign kp_valid  = (fill != '0);
    assign pop       = kp_valid && kp_ready;

    always_comb begin
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (mask_q[i]) idx = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        emit    = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (slot_free) begin
                    emit   = 1'b1;
                    mask_d = mask_q & ~low_bit;
                    if (last) state_d = IDLE;
                end
                // A new pixel fits only if the last pending flag leaves on this edge.
                if (cap) begin
                    if (slot_free && last) begin
                        load    = 1'b1;
                        state_d = SCAN;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) mask_d = max_flag;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            px_q <= x;
            py_q <= y;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_scale[wr_ptr] <= idx;
            mem_x[wr_ptr]     <= px_q;
            mem_y[wr_ptr]     <= py_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kp_count <= 11'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (frame_start)   kp_count <= push ? 11'd1 : 11'd0;
            else if (push)     kp_count <= kp_count + 11'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign kp_scale = kp_valid ? mem_scale[rd_ptr] : 3'd0;
    assign kp_x     = kp_valid ? mem_x[rd_ptr]     : 10'd0;
    assign kp_y     = kp_valid ? mem_y[rd_ptr]     : 10'd0;

`ifdef KPC_RESPONSE_STORE_EN
    logic [6*DATA_WIDTH-1:0] pr_q;
    logic [DATA_WIDTH-1:0]   mem_resp [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (load) pr_q <= response;
    end

    always_ff @(posedge clk) begin
        if (push) mem_resp[wr_ptr] <= pr_q[32'(idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign kp_response = kp_valid ? mem_resp[rd_ptr] : '0;
`else
    logic unused_response;
    assign unused_response = ^response;
    assign kp_response     = '0;
`endif

endmodule

// File: tb/tb_keypoint_collector.sv
// Bench for keypoint_collector: directed vector table, multi-cycle sequences and a
// random run compared every cycle against a queue-based reference model.
module tb_keypoint_collector;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int MAXK  = 1023;

    logic          clk = 1'b0;
    logic          rst_n, frame_start, din_valid, kp_ready;
    logic [5:0]    max_flag;
    logic [6*DW-1:0] response;
    logic [9:0]    x, y;
    logic          kp_valid, kp_valid_4;
    logic [2:0]    kp_scale, kp_scale_4;
    logic [9:0]    kp_x, kp_y, kp_x_4, kp_y_4;
    logic [DW-1:0] kp_response, kp_response_4;
    logic [10:0]   kp_count, kp_count_4;
    logic [15:0]   drop_cnt, drop_cnt_4;

    int errors = 0;
    int checks = 0;
    int rec4   = 0;

    always #5 clk = ~clk;

    keypoint_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_KP(MAXK)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .din_valid(din_valid),
        .max_flag(max_flag), .response(response), .x(x), .y(y), .kp_ready(kp_ready),
        .kp_valid(kp_valid), .kp_scale(kp_scale), .kp_x(kp_x), .kp_y(kp_y),
        .kp_response(kp_response), .kp_count(kp_count), .drop_cnt(drop_cnt)
    );

    keypoint_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_KP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .din_valid(din_valid),
        .max_flag(max_flag), .response(response), .x(x), .y(y), .kp_ready(kp_ready),
        .kp_valid(kp_valid_4), .kp_scale(kp_scale_4), .kp_x(kp_x_4), .kp_y(kp_y_4),
        .kp_response(kp_response_4), .kp_count(kp_count_4), .drop_cnt(drop_cnt_4)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  s;
        logic [9:0]  rx;
        logic [9:0]  ry;
        logic [DW-1:0] r;
    } rec_t;

    rec_t          fifo_m[$];
    int            pend_m[$];
    logic [9:0]    mpx, mpy;
    logic [6*DW-1:0] mpr;
    int            mcount = 0;
    int            mdrop  = 0;

    function automatic void model_update();
        bit was_empty, stall, emitted_last, pushed;
        rec_t rc;
        int s;
        if (!rst_n) begin
            fifo_m.delete();
            pend_m.delete();
            mcount = 0;
            mdrop  = 0;
            return;
        end
        was_empty    = (pend_m.size() == 0);
        stall        = (fifo_m.size() == DEPTH);
        emitted_last = 0;
        pushed       = 0;
        if (fifo_m.size() != 0 && kp_ready) void'(fifo_m.pop_front());
        if (!was_empty && !stall) begin
            s = pend_m.pop_front();
            if (mcount < MAXK) begin
                rc.s  = 3'(s);
                rc.rx = mpx;
                rc.ry = mpy;
`ifdef KPC_RESPONSE_STORE_EN
                rc.r  = mpr[s*DW +: DW];
`else
                rc.r  = '0;
`endif
                fifo_m.push_back(rc);
                mcount++;
                pushed = 1;
            end
            emitted_last = (pend_m.size() == 0);
        end
        if (din_valid && max_flag != 0) begin
            if (was_empty || emitted_last) begin
                for (int i = 0; i < 6; i++) if (max_flag[i]) pend_m.push_back(i);
                mpx = x;
                mpy = y;
                mpr = response;
            end else if (mdrop < 65535) begin
                mdrop++;
            end
        end
        if (frame_start) mcount = pushed ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        rec_t h;
        if (fifo_m.size() != 0) begin
            h = fifo_m[0];
            check("model", {kp_valid, kp_scale, kp_x, kp_y, kp_response, kp_count, drop_cnt},
                  {1'b1, h.s, h.rx, h.ry, h.r, 11'(mcount), 16'(mdrop)});
        end else begin
            check("model_empty", {kp_valid, kp_count, drop_cnt}, {1'b0, 11'(mcount), 16'(mdrop)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
        if (kp_valid_4 === 1'b1) rec4++;
    endtask

    task automatic drive(input logic r, input logic fs, input logic dv, input logic [5:0] f,
                         input logic [9:0] px, input logic [9:0] py, input logic rdy);
        rst_n       = r;
        frame_start = fs;
        din_valid   = dv;
        max_flag    = f;
        x           = px;
        y           = py;
        kp_ready    = rdy;
        for (int i = 0; i < 6; i++) response[i*DW +: DW] = $urandom();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       fs;
        logic       dv;
        logic [5:0] flag;
        logic [9:0] px;
        logic [9:0] py;
        logic       rdy;
        logic       e_valid;
        logic [2:0] e_scale;
        logic [9:0] e_x;
        logic [9:0] e_y;
        logic [10:0] e_count;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vt[17];

    initial begin
        int got;
        int seen;
        vt[0]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd0, 16'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 6'b000100, 10'd100, 10'd50, 1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd0, 16'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd2, 10'd100, 10'd50, 11'd1, 16'd0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd1, 16'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 6'b101001, 10'd7,   10'd9,  1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd0, 16'd0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd0, 10'd7,   10'd9,  11'd1, 16'd0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd3, 10'd7,   10'd9,  11'd2, 16'd0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd5, 10'd7,   10'd9,  11'd3, 16'd0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd3, 16'd0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 6'b111111, 10'd1,   10'd2,  1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd3, 16'd0};
        vt[10] = '{1'b1, 1'b0, 1'b1, 6'b000001, 10'd3,   10'd4,  1'b1, 1'b1, 3'd0, 10'd1,   10'd2,  11'd4, 16'd1};
        vt[11] = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd1, 10'd1,   10'd2,  11'd5, 16'd1};
        vt[12] = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd2, 10'd1,   10'd2,  11'd6, 16'd1};
        vt[13] = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd3, 10'd1,   10'd2,  11'd7, 16'd1};
        vt[14] = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd4, 10'd1,   10'd2,  11'd8, 16'd1};
        vt[15] = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b1, 3'd5, 10'd1,   10'd2,  11'd9, 16'd1};
        vt[16] = '{1'b1, 1'b0, 1'b0, 6'b000000, 10'd0,   10'd0,  1'b1, 1'b0, 3'd0, 10'd0,   10'd0,  11'd9, 16'd1};

        drive(1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].rst, vt[i].fs, vt[i].dv, vt[i].flag, vt[i].px, vt[i].py, vt[i].rdy);
            step();
            check($sformatf("vec%0d_ctl", i), {kp_valid, kp_count, drop_cnt},
                  {vt[i].e_valid, vt[i].e_count, vt[i].e_drop});
            if (vt[i].e_valid)
                check($sformatf("vec%0d_rec", i), {kp_scale, kp_x, kp_y},
                      {vt[i].e_scale, vt[i].e_x, vt[i].e_y});
        end

        // Backpressure: FIFO fills, scan stalls, later pixels dropped, then ordered drain.
        drive(1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b0);
        step();
        for (int j = 0; j < DEPTH + 3; j++) begin
            drive(1'b1, 1'b0, 1'b1, 6'(1 << (j % 6)), 10'(j * 3), 10'(j), 1'b0);
            step();
            drive(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b0);
            step();
        end
        check("bp_stall", {kp_valid, kp_count, drop_cnt}, {1'b1, 11'd16, 16'd2});
        got = 0;
        drive(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            if (kp_valid) begin
                check("bp_order", kp_x, 10'(got * 3));
                got++;
            end
            step();
        end
        check("bp_total", got, DEPTH + 1);

        // MAX_KP=4 instance: six pixels, frame_start, one pixel.
        drive(1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
        step();
        rec4 = 0;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 1'b0, 1'b1, 6'b000010, 10'(j + 20), 10'd5, 1'b1);
            step();
            drive(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
            step();
        end
        step();
        check("maxkp_count", kp_count_4, 11'd4);
        check("maxkp_records", rec4, 4);
        drive(1'b1, 1'b1, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
        step();
        check("maxkp_frame", kp_count_4, 11'd0);
        drive(1'b1, 1'b0, 1'b1, 6'b000001, 10'd33, 10'd44, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
        step();
        check("maxkp_after", kp_count_4, 11'd1);

        // Reset in the middle of a six-flag scan.
        drive(1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 6'b111111, 10'd9, 10'd8, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
        step();
        check("rst_mid", {kp_valid, kp_count}, {1'b0, 11'd0});
        seen = 0;
        drive(1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step();
            if (kp_valid) seen++;
        end
        check("rst_no_records", seen, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom()),
                  10'($urandom()), 10'($urandom()), ($urandom_range(0, 2) != 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
